reset_domain_sequencer: RTL
===========================

RESET_DOMAIN_SEQUENCER -- requirements
Module: reset_domain_sequencer

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 4: number of sequenced child reset domains (2..16).
REQ-002 SHALL have parameter GAP, default 8: settle cycles between consecutive domain steps (0..255).
REQ-003 SHALL have parameter TIMEOUT, default 1023: max wait cycles per domain acknowledge (1..65535).
REQ-004 SHALL have port clock  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port up_request  input  1  parent asks the sequenced group to run.
REQ-007 SHALL have ports up_ready, up_silent, up_starting, up_stopping  output  1 each  group status toward parent, one-hot.
REQ-008 SHALL have port dom_request  output  N_DOMAINS  per-domain run request, bit i to domain i.
REQ-009 SHALL have ports dom_ready, dom_silent  input  N_DOMAINS each  per-domain status from child reset modules.
REQ-010 SHALL have port error  output  1  sticky timeout flag.
REQ-011 SHALL have port error_index  output  clog2(N_DOMAINS)  domain that timed out first.

Function
REQ-012 SHALL implement states SILENT, START_WAIT, START_GAP, READY, STOP_WAIT, STOP_GAP; index register idx tracks current domain.
REQ-013 SHALL drive up_silent in SILENT, up_starting in START_*, up_ready in READY, up_stopping in STOP_*, all registered.
REQ-014 SILENT with up_request=1 and error=0 SHALL go START_WAIT, idx=0, dom_request[0]=1 on the next cycle.
REQ-015 START_WAIT SHALL hold until dom_ready[idx]=1; then START_GAP if idx<N_DOMAINS-1, else READY.
REQ-016 START_GAP SHALL count GAP cycles, then set idx+1, assert dom_request[idx+1], enter START_WAIT; GAP=0 advances immediately.
REQ-017 dom_request bits SHALL be monotonic during start: bits 0..idx set, higher bits clear.
REQ-018 READY with up_request=0 SHALL go STOP_WAIT, idx=N_DOMAINS-1, clear dom_request[N_DOMAINS-1] on the next cycle.
REQ-019 STOP_WAIT SHALL hold until dom_silent[idx]=1; then STOP_GAP if idx>0, else SILENT.
REQ-020 STOP_GAP SHALL count GAP cycles, then decrement idx, clear dom_request[idx-1], enter STOP_WAIT.
REQ-021 up_request falling in START_WAIT/START_GAP SHALL clear dom_request[idx] next cycle and enter STOP_WAIT at current idx (reverse from partial start).
REQ-022 up_request rising during STOP_* SHALL be ignored until SILENT is reached; restart then follows REQ-014.
REQ-023 A single counter SHALL serve GAP and TIMEOUT; it SHALL clear on every state or idx change.
REQ-024 In START_WAIT, TIMEOUT cycles without dom_ready[idx] SHALL set error, latch error_index=idx (if error was 0), and proceed as REQ-021.
REQ-025 In STOP_WAIT, TIMEOUT cycles without dom_silent[idx] SHALL set error/error_index as REQ-024 and proceed as if silent was seen.
REQ-026 While error=1, SILENT SHALL ignore up_request; error clears only by reset.
REQ-027 Status inputs for domains other than idx SHALL be ignored.

Reset
REQ-028 reset=1 SHALL force SILENT, idx=0, counter=0, dom_request=0, up_silent=1, other up_* =0, error=0, error_index=0 on the next edge.
REQ-029 reset mid-sequence SHALL drop all dom_request bits at once; no ordered stop is performed.

Structure
REQ-030 State enum and status encoding SHALL live in shared package reset_pkg.
REQ-031 Counter SHALL be sub-module reset_seq_timer (load, enable, terminal-count outputs for GAP and TIMEOUT).
REQ-032 All outputs SHALL be registered; no combinational input-to-output path.

Verification (N_DOMAINS=4, GAP=2, TIMEOUT=15)
REQ-033 Full start: up_request=1, each dom_ready[i] 3 cycles after its request -> dom_request 0001,0011,0111,1111 spaced 5 cycles, up_ready after dom_ready[3].
REQ-034 Full stop: from READY drop up_request, dom_silent 3 cycles after clear -> bits clear 3,2,1,0 in order, up_silent ends 1.
REQ-035 Abort: drop up_request while idx=1 in START_WAIT -> dom_request[1] clears next cycle, then bit 0 after dom_silent[1]+GAP, SILENT, error=0.
REQ-036 Start timeout: dom_ready[2] never asserts -> after 15 cycles error=1, error_index=2, reverse stop from 2, later up_request pulses ignored.
REQ-037 Stop timeout: dom_silent[3] stuck low -> error=1, error_index=3, sequencer continues to domain 2 after 15+2 cycles.
REQ-038 Reset mid-start (idx=2): reset=1 one cycle -> dom_request=0000, up_silent=1, error=0 next edge.

Source files
------------

// File: rtl/reset_pkg.sv
// Shared types for the reset domain sequencer.
// The state enum and the one-hot group status toward the parent.
package reset_pkg;

    typedef enum logic [2:0] {
        ST_SILENT,
        ST_START_WAIT,
        ST_START_GAP,
        ST_READY,
        ST_STOP_WAIT,
        ST_STOP_GAP
    } seq_state_t;

    typedef struct packed {
        logic ready;
        logic silent;
        logic starting;
        logic stopping;
    } up_status_t;

    function automatic up_status_t status_of(input seq_state_t s);
        up_status_t r;
        r = '0;
        case (s)
            ST_SILENT:                   r.silent   = 1'b1;
            ST_START_WAIT, ST_START_GAP: r.starting = 1'b1;
            ST_READY:                    r.ready    = 1'b1;
            default:                     r.stopping = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Shared settle/timeout counter for the sequencer.
// One count serves both the gap and the acknowledge timeout.
module reset_seq_timer #(
    parameter int GAP     = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic gap_tc,
    output logic tmo_tc
);

    localparam logic [15:0] GAP_LAST = 16'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (enable && cnt != 16'hffff) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign gap_tc = (cnt == GAP_LAST);
    assign tmo_tc = (cnt == TMO_LAST);

endmodule

// File: rtl/reset_domain_sequencer.sv
// Brings child reset domains up in order 0..N-1 and down in reverse,
// with a settle gap between steps and a sticky acknowledge timeout.
module reset_domain_sequencer
    import reset_pkg::*;
#(
    parameter int N_DOMAINS = 4,
    parameter int GAP       = 8,
    parameter int TIMEOUT   = 1023
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         up_request,
    output logic                         up_ready,
    output logic                         up_silent,
    output logic                         up_starting,
    output logic                         up_stopping,
    output logic [N_DOMAINS-1:0]         dom_request,
    input  logic [N_DOMAINS-1:0]         dom_ready,
    input  logic [N_DOMAINS-1:0]         dom_silent,
    output logic                         error,
    output logic [$clog2(N_DOMAINS)-1:0] error_index
);

    localparam int            IW   = $clog2(N_DOMAINS);
    localparam logic [IW-1:0] LAST = IW'(N_DOMAINS - 1);

    seq_state_t           st, st_n;
    logic [IW-1:0]        idx, idx_n;
    logic [N_DOMAINS-1:0] req_q, req_n;
    logic                 err_q, err_n;
    logic [IW-1:0]        eidx_q, eidx_n;
    up_status_t           stat_q;
    logic                 fault;
    logic                 tmr_load, tmr_en;
    logic                 gap_tc, tmo_tc;

    // Any move of state or index restarts the shared count.
    assign tmr_load = (st_n != st) || (idx_n != idx);
    assign tmr_en   = (st != ST_SILENT) && (st != ST_READY);

    reset_seq_timer #(
        .GAP     (GAP),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (tmr_load),
        .enable (tmr_en),
        .gap_tc (gap_tc),
        .tmo_tc (tmo_tc)
    );

    always_comb begin
        st_n   = st;
        idx_n  = idx;
        req_n  = req_q;
        err_n  = err_q;
        eidx_n = eidx_q;
        fault  = 1'b0;
        unique case (st)
            ST_SILENT: begin
                if (up_request && !err_q) begin
                    st_n     = ST_START_WAIT;
                    idx_n    = '0;
                    req_n[0] = 1'b1;
                end
            end
            ST_START_WAIT: begin
                if (up_request && dom_ready[idx]) begin
                    if (idx == LAST) begin
                        st_n = ST_READY;
                    end else if (GAP == 0) begin
                        idx_n        = idx + 1'b1;
                        req_n[idx_n] = 1'b1;
                    end else begin
                        st_n = ST_START_GAP;
                    end
                end else if (!up_request || tmo_tc) begin
                    // Timeout unwinds exactly like a parent abort.
                    fault      = tmo_tc && !dom_ready[idx];
                    req_n[idx] = 1'b0;
                    st_n       = ST_STOP_WAIT;
                end
            end
            ST_START_GAP: begin
                if (!up_request) begin
                    req_n[idx] = 1'b0;
                    st_n       = ST_STOP_WAIT;
                end else if (gap_tc) begin
                    idx_n        = idx + 1'b1;
                    req_n[idx_n] = 1'b1;
                    st_n         = ST_START_WAIT;
                end
            end
            ST_READY: begin
                if (!up_request) begin
                    st_n        = ST_STOP_WAIT;
                    idx_n       = LAST;
                    req_n[LAST] = 1'b0;
                end
            end
            ST_STOP_WAIT: begin
                if (dom_silent[idx] || tmo_tc) begin
                    fault = tmo_tc && !dom_silent[idx];
                    if (idx == '0) begin
                        st_n = ST_SILENT;
                    end else if (GAP == 0) begin
                        idx_n        = idx - 1'b1;
                        req_n[idx_n] = 1'b0;
                    end else begin
                        st_n = ST_STOP_GAP;
                    end
                end
            end
            ST_STOP_GAP: begin
                if (gap_tc) begin
                    idx_n        = idx - 1'b1;
                    req_n[idx_n] = 1'b0;
                    st_n         = ST_STOP_WAIT;
                end
            end
            default: begin
                st_n  = ST_SILENT;
                idx_n = '0;
                req_n = '0;
            end
        endcase
        if (fault) begin
            err_n = 1'b1;
            if (!err_q) begin
                eidx_n = idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st     <= ST_SILENT;
            idx    <= '0;
            req_q  <= '0;
            err_q  <= 1'b0;
            eidx_q <= '0;
            stat_q <= status_of(ST_SILENT);
        end else begin
            st     <= st_n;
            idx    <= idx_n;
            req_q  <= req_n;
            err_q  <= err_n;
            eidx_q <= eidx_n;
            stat_q <= status_of(st_n);
        end
    end

    assign dom_request = req_q;
    assign error       = err_q;
    assign error_index = eidx_q;
    assign up_ready    = stat_q.ready;
    assign up_silent   = stat_q.silent;
    assign up_starting = stat_q.starting;
    assign up_stopping = stat_q.stopping;

endmodule
